// File: rtl/output_channel_sequencer.sv
// output_channel_sequencer: steps the output mux through the filter channels
// (auto-scan over a channel mask, or a host-chosen manual channel) and presents
// each sample with a valid/ready handshake, aligned to the mux's registered data.
// Optional build macro SEQ_STALL_DROP_EN: in auto-scan, a sample stalled for 16
// cycles is dropped and counted on o_drop_count.
module output_channel_sequencer #(
    parameter int NUM_FILTERS = 8,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic                   i_auto_scan,
    input  logic [7:0]             i_manual_channel,
    input  logic [NUM_FILTERS-1:0] i_channel_mask,
    input  logic [DWELL_WIDTH-1:0] i_dwell_cycles,
    input  logic                   i_ready,
    output logic [7:0]             o_select_output_channel,
    output logic                   o_valid,
    output logic [7:0]             o_channel_tag,
    output logic                   o_frame_start
`ifdef SEQ_STALL_DROP_EN
    ,
    output logic [7:0]             o_drop_count
`endif
);

    typedef enum logic [1:0] {IDLE, SELECT, PRESENT, DWELL} state_t;

    state_t                 state_q, state_d, adv_state;
    logic [7:0]             chan_q, chan_d, adv_chan;
    logic                   frame_q, frame_d, adv_frame;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [7:0]             manual_clamped, mask_first, mask_next;
    logic                   mask_any, take_adv;

`ifdef SEQ_STALL_DROP_EN
    logic [3:0] stall_q, stall_d;
    logic       auto_q;
    logic       drop;
    logic [7:0] drop_cnt_q;
`endif

    // Lowest set bit of the mask (0 when empty; callers check mask_any).
    function automatic logic [7:0] first_set(input logic [NUM_FILTERS-1:0] m);
        first_set = '0;
        for (int n = NUM_FILTERS - 1; n >= 0; n--)
            if (m[n]) first_set = 8'(n);
    endfunction

    // Lowest set bit strictly above cur, wrapping to the lowest set bit.
    function automatic logic [7:0] next_set(input logic [NUM_FILTERS-1:0] m,
                                            input logic [7:0] cur);
        next_set = first_set(m);
        for (int n = NUM_FILTERS - 1; n >= 0; n--)
            if (m[n] && (8'(n) > cur)) next_set = 8'(n);
    endfunction

    assign mask_any       = |i_channel_mask;
    assign mask_first     = first_set(i_channel_mask);
    assign mask_next      = next_set(i_channel_mask, chan_q);
    assign manual_clamped = (i_manual_channel < 8'(NUM_FILTERS)) ? i_manual_channel : 8'd0;

    // Advance step: mode and mask are only looked at when leaving PRESENT/DWELL.
    always_comb begin
        adv_state = SELECT;
        adv_chan  = chan_q;
        adv_frame = 1'b0;
        if (i_auto_scan) begin
            if (mask_any) begin
                adv_chan  = mask_next;
                adv_frame = (mask_next == mask_first);
            end else begin
                adv_state = IDLE;
            end
        end else begin
            adv_chan = manual_clamped;
        end
    end

    // Next-state logic; disable overrides everything and leaves the mux select alone.
    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        frame_d  = frame_q;
        dwell_d  = dwell_q;
        take_adv = 1'b0;
`ifdef SEQ_STALL_DROP_EN
        stall_d  = '0;
        drop     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_auto_scan) begin
                    if (mask_any) begin
                        chan_d  = mask_first;
                        frame_d = 1'b1;
                        state_d = SELECT;
                    end
                end else begin
                    chan_d  = manual_clamped;
                    frame_d = 1'b0;
                    state_d = SELECT;
                end
            end
            // Mux registers the new select during this cycle.
            SELECT: state_d = PRESENT;
            PRESENT: begin
                if (i_ready) begin
                    if (i_dwell_cycles == '0) begin
                        take_adv = 1'b1;
                    end else begin
                        dwell_d = i_dwell_cycles;
                        state_d = DWELL;
                    end
                end
`ifdef SEQ_STALL_DROP_EN
                else if (auto_q && (stall_q == 4'hF)) begin
                    take_adv = 1'b1;
                    drop     = 1'b1;
                end else begin
                    stall_d = stall_q + 4'd1;
                end
`endif
            end
            DWELL: begin
                dwell_d = dwell_q - DWELL_WIDTH'(1);
                if (dwell_q <= DWELL_WIDTH'(1)) take_adv = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (take_adv) begin
            state_d = adv_state;
            chan_d  = adv_chan;
            frame_d = adv_frame;
        end
        if (!i_enable) begin
            state_d = IDLE;
            chan_d  = chan_q;
            frame_d = frame_q;
`ifdef SEQ_STALL_DROP_EN
            drop    = 1'b0;
`endif
        end
    end

    // State and channel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            chan_q  <= '0;
            frame_q <= 1'b0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            frame_q <= frame_d;
            dwell_q <= dwell_d;
        end
    end

`ifdef SEQ_STALL_DROP_EN
    // Stall timer, mode of the sample being presented, and saturating drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q    <= '0;
            auto_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            stall_q <= stall_d;
            if (state_d == SELECT) auto_q <= i_auto_scan;
            if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign o_drop_count = drop_cnt_q;
`endif

    assign o_valid                 = (state_q == PRESENT);
    assign o_frame_start           = o_valid & frame_q;
    assign o_select_output_channel = chan_q;
    assign o_channel_tag           = chan_q;

endmodule

// File: tb/tb_output_channel_sequencer.sv
// Bench for output_channel_sequencer: directed phases plus a sample-level model
// (channel order from the mask, idle gap from dwell, stall/disable rules).
module tb_output_channel_sequencer;
    localparam int NF = 8;
    localparam int DW = 8;
`ifdef SEQ_STALL_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          auto = 1'b1;
    logic          rdy = 1'b1;
    logic [7:0]    man = 8'd0;
    logic [NF-1:0] mask = '0;
    logic [DW-1:0] dwell = '0;
    logic [7:0]    sel, tag;
    logic          vld, fs;
`ifdef SEQ_STALL_DROP_EN
    logic [7:0]    drops;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    output_channel_sequencer #(.NUM_FILTERS(NF), .DWELL_WIDTH(DW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .i_enable                (en),
        .i_auto_scan             (auto),
        .i_manual_channel        (man),
        .i_channel_mask          (mask),
        .i_dwell_cycles          (dwell),
        .i_ready                 (rdy),
        .o_select_output_channel (sel),
        .o_valid                 (vld),
        .o_channel_tag           (tag),
        .o_frame_start           (fs)
`ifdef SEQ_STALL_DROP_EN
        ,
        .o_drop_count            (drops)
`endif
    );

    // Stand-in for the registered output mux: filter n outputs n*17.
    logic [7:0] mux_q, mux_data;
    always @(posedge clk) mux_q <= sel;
    assign mux_data = mux_q * 8'd17;

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NF-1:0] m);
        for (int i = 0; i < NF; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int next_above(input logic [NF-1:0] m, input int c);
        for (int i = c + 1; i < NF; i++) if (m[i]) return i;
        return lowest(m);
    endfunction

    // ---------------- model / compare state ----------------
    bit            p_rst = 1'b1, p_en = 1'b0, p_v = 1'b0, p_f = 1'b0, p_xfer = 1'b0, p_drop = 1'b0;
    int            p_t = 0;
    logic          h1_auto = 1'b0, h2_auto = 1'b0;
    logic [NF-1:0] h1_mask = '0, h2_mask = '0;
    logic [7:0]    h1_man = '0, h2_man = '0;
    bit            have_prev = 1'b0, gap_ok = 1'b0, smp_auto = 1'b0;
    int            last = 0, gap_cnt = 0, exp_gap = 0, stall = 0;
    int            tags_q[$];
    bit            frames_q[$];

    // Compare process: outputs sampled on the falling edge, inputs are stable then.
    always @(negedge clk) begin
        bit xfer, drop, ef;
        int e;
        xfer = 1'b0;
        drop = 1'b0;
        if (p_rst) begin
            chk_eq("reset_valid", vld, 0);
            chk_eq("reset_tag", tag, 0);
            chk_eq("reset_select", sel, 0);
            chk_eq("reset_frame", fs, 0);
            have_prev = 1'b0;
            gap_ok    = 1'b0;
            stall     = 0;
        end else begin
            chk_eq("frame_only_with_valid", int'(fs && !vld), 0);
            if (vld) begin
                chk_eq("select_eq_tag", sel, tag);
                chk_eq("mux_data", mux_data, int'(tag) * 17);
            end
            if (!p_en) begin
                chk_eq("disable_drops_valid", vld, 0);
                have_prev = 1'b0;
                gap_ok    = 1'b0;
            end else if (p_v) begin
                if (p_xfer || p_drop) begin
                    chk_eq("valid_falls_after_accept", vld, 0);
                end else begin
                    chk_eq("valid_held_in_stall", vld, 1);
                    chk_eq("tag_stable_in_stall", tag, p_t);
                    chk_eq("frame_stable_in_stall", fs, p_f);
                end
            end
            if (!vld) gap_cnt++;
            // New sample: channel came from mode/mask at the edge entering SELECT.
            if (vld && !p_v && p_en) begin
                if (h2_auto) begin
                    e  = have_prev ? next_above(h2_mask, last) : lowest(h2_mask);
                    ef = (e == lowest(h2_mask));
                end else begin
                    e  = (int'(h2_man) < NF) ? int'(h2_man) : 0;
                    ef = 1'b0;
                end
                chk_eq("sample_tag", tag, e);
                chk_eq("sample_frame", fs, ef);
                if (gap_ok) chk_eq("idle_gap", gap_cnt, exp_gap);
                gap_ok   = 1'b0;
                smp_auto = h2_auto;
                tags_q.push_back(int'(tag));
                frames_q.push_back(fs);
            end
            stall = (vld && !rdy) ? stall + 1 : 0;
            xfer  = vld && rdy && en && !rst;
            drop  = DROP && vld && !rdy && en && !rst && smp_auto && (stall == 16);
            if (xfer || drop) begin
                last      = tag;
                have_prev = 1'b1;
                gap_cnt   = 0;
                exp_gap   = xfer ? int'(dwell) + 1 : 1;
                gap_ok    = 1'b1;
            end
        end
        p_rst   = rst;
        p_en    = en;
        p_v     = vld;
        p_t     = tag;
        p_f     = fs;
        p_xfer  = xfer;
        p_drop  = drop;
        h2_auto = h1_auto;
        h2_mask = h1_mask;
        h2_man  = h1_man;
        h1_auto = auto;
        h1_mask = mask;
        h1_man  = man;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_samples(input int n, input int budget);
        int target;
        int c;
        target = tags_q.size() + n;
        c = 0;
        while (tags_q.size() < target && c < budget) begin
            tick(1);
            c++;
        end
        chk_eq("sample_wait_in_time", int'(tags_q.size() >= target), 1);
    endtask

    int exp1[6] = '{0, 2, 5, 7, 0, 2};
    bit ef1[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int base, low, cnt;
        tick(2);
        chk_eq("reset_literal_valid", vld, 0);
        chk_eq("reset_literal_select", sel, 0);
        rst = 1'b0;

        // Auto-scan order over mask 1010_0101, dwell 0, ready high.
        mask = 8'b1010_0101; dwell = '0; rdy = 1'b1; auto = 1'b1; en = 1'b1;
        base = tags_q.size();
        wait_samples(6, 40);
        for (int i = 0; i < 6; i++) begin
            if (base + i < tags_q.size()) begin
                chk_eq("scan_order_tag", tags_q[base+i], exp1[i]);
                chk_eq("scan_order_frame", frames_q[base+i], ef1[i]);
            end
        end

        // Stall on channel 3 for 5 cycles, then dwell 4.
        en = 1'b0; tick(1);
        mask = 8'h18; dwell = 8'd4; rdy = 1'b0; en = 1'b1;
        base = tags_q.size();
        wait_samples(1, 10);
        if (base < tags_q.size()) chk_eq("stall_first_tag", tags_q[base], 3);
        for (int i = 0; i < 5; i++) begin
            chk_eq("stall_valid_held", vld, 1);
            chk_eq("stall_tag_held", tag, 3);
            tick(1);
        end
        rdy = 1'b1;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (vld) break;
            low++;
        end
        chk_eq("dwell4_low_cycles", low, 4 + 1); // 4 dwell cycles then SELECT
        chk_eq("after_dwell_tag", tag, 4);

        // Manual mode with out-of-range channel clamps to 0, then channel 6.
        en = 1'b0; tick(1);
        auto = 1'b0; man = 8'd9; dwell = '0; rdy = 1'b1; en = 1'b1;
        base = tags_q.size();
        wait_samples(3, 20);
        for (int i = 0; i < 3; i++) begin
            if (base + i < tags_q.size()) begin
                chk_eq("manual_clamp_tag", tags_q[base+i], 0);
                chk_eq("manual_frame", frames_q[base+i], 0);
            end
        end
        man = 8'd6;
        base = tags_q.size();
        wait_samples(2, 20);
        if (base + 1 < tags_q.size()) begin
            chk_eq("manual_switch_tag", tags_q[base+1], 6);
            chk_eq("manual_switch_frame", frames_q[base+1], 0);
        end

        // Empty mask stays idle; mask change during dwell picks channel 7.
        en = 1'b0; tick(1);
        auto = 1'b1; mask = '0; en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (vld) cnt++;
        end
        chk_eq("empty_mask_no_valid", cnt, 0);
        mask = 8'h01; dwell = 8'd6;
        base = tags_q.size();
        wait_samples(1, 10);
        if (base < tags_q.size()) chk_eq("mask01_tag", tags_q[base], 0);
        tick(2);
        mask = 8'h80;
        wait_samples(1, 20);
        if (base + 1 < tags_q.size()) begin
            chk_eq("mask80_tag", tags_q[base+1], 7);
            chk_eq("mask80_frame", frames_q[base+1], 1);
        end

        // Disable while stalled on channel 2.
        en = 1'b0; tick(1);
        mask = 8'h04; dwell = '0; rdy = 1'b0; en = 1'b1;
        wait_samples(1, 10);
`ifndef SEQ_STALL_DROP_EN
        tick(20);
        chk_eq("long_stall_valid", vld, 1);
        chk_eq("long_stall_tag", tag, 2);
`endif
        en = 1'b0;
        tick(1);
        chk_eq("disable_valid_low", vld, 0);
        chk_eq("disable_select_kept", sel, 2);
        tick(3);
        chk_eq("disable_stays_idle", vld, 0);

        // Reset while in DWELL.
        dwell = 8'd5; rdy = 1'b1; en = 1'b1;
        wait_samples(1, 10);
        rst = 1'b1;
        tick(1);
        chk_eq("rst_dwell_valid", vld, 0);
        chk_eq("rst_dwell_tag", tag, 0);
        chk_eq("rst_dwell_select", sel, 0);
        chk_eq("rst_dwell_frame", fs, 0);
`ifdef SEQ_STALL_DROP_EN
        chk_eq("rst_drop_count", drops, 0);
`endif
        rst = 1'b0;

`ifdef SEQ_STALL_DROP_EN
        // Stall drop: channel 2 dropped after 16 cycles, next is 3; then saturate.
        en = 1'b0; tick(1);
        mask = 8'h04; rdy = 1'b0; dwell = '0; en = 1'b1;
        wait_samples(1, 10);
        mask = 8'h0F;
        base = tags_q.size();
        wait_samples(1, 40);
        if (base < tags_q.size()) chk_eq("drop_next_tag", tags_q[base], 3);
        chk_eq("drop_count_one", drops, 1);
        tick(300 * 17);
        chk_eq("drop_count_saturated", drops, 255);
`endif

        en = 1'b0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
